// File: rtl/custom_axi_ip_pkg.sv
// Shared types and constants for the custom AXI IP core and its host register file.
// Holds the core state encoding, the register map offsets, STATUS/CTRL bit
// positions and the AXI response codes used by custom_axi_ip_regs.
package custom_axi_ip_pkg;

  // Core state as reported on core_status_i
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } status_e;

  // Register byte offsets; decode uses bits [3:2]
  localparam logic [3:0] CTRL_OFFS     = 4'h0;
  localparam logic [3:0] DATA_IN_OFFS  = 4'h4;
  localparam logic [3:0] DATA_OUT_OFFS = 4'h8;
  localparam logic [3:0] STATUS_OFFS   = 4'hC;

  // CTRL bit positions
  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  // STATUS bit positions
  localparam int unsigned STATUS_STATE_LSB = 0;
  localparam int unsigned STATUS_STATE_MSB = 1;
  localparam int unsigned STATUS_DONE_BIT  = 2;
  localparam int unsigned STATUS_ERR_BIT   = 3;
  localparam int unsigned STATUS_REJ_BIT   = 4;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite slave register file in front of the custom AXI IP core.
// Holds the operand (DATA_IN), issues a one-cycle start pulse on enable_o,
// exposes the live core result/state and keeps sticky DONE/ERROR/START_REJECTED
// flags. Optional feature macro: CUSTOM_AXI_IP_REGS_IRQ_EN adds CTRL[1]
// IRQ_ENABLE and a registered irq_o output.
module custom_axi_ip_regs
  import custom_axi_ip_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  // write response channel
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  // read data channel
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  // core interface
  output logic [DATA_WIDTH-1:0]   ipreg_data_o,
  output logic                    enable_o,
  input  logic [DATA_WIDTH-1:0]   core_data_i,
  input  status_e                 core_status_i
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned SW = DATA_WIDTH / 8;

  // write channel state
  logic                  r_aw_lat;
  logic                  r_w_lat;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DW-1:0]         r_wdata;
  logic [SW-1:0]         r_wstrb;

  // read channel state
  logic                  r_arready;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DW-1:0]         r_rdata;

  // register contents
  logic [DW-1:0]         r_data_in;
  logic                  r_enable;
  logic                  r_done_sticky;
  logic                  r_err_sticky;
  logic                  r_start_rej;
  status_e               r_prev_status;

  // write-path combinational signals
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_aw_have;
  logic                  w_w_have;
  logic                  w_commit;
  logic                  w_aw_lat_nxt;
  logic                  w_w_lat_nxt;
  logic                  w_bvalid_nxt;
  logic [ADDR_WIDTH-1:0] w_awaddr_eff;
  logic [DW-1:0]         w_wdata_eff;
  logic [SW-1:0]         w_wstrb_eff;
  logic                  w_wr_oob;
  logic                  w_wr_ok;
  logic                  w_wr_ctrl;
  logic                  w_wr_data_in;
  logic                  w_wr_status;
  logic                  w_start_req;
  logic                  w_core_idle;
  logic                  w_w1c_en;
  logic                  w_done_set;
  logic                  w_err_set;

  // read-path combinational signals
  logic                  w_ar_hs;
  logic                  w_rvalid_nxt;
  logic                  w_rd_oob;
  logic [DW-1:0]         w_rd_word;

`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  logic                  r_irq_en;
  logic                  r_irq;
`endif

  // AW/W may arrive together or apart; a beat arriving this cycle counts as latched
  assign w_aw_hs      = s_awvalid & r_awready;
  assign w_w_hs       = s_wvalid & r_wready;
  assign w_b_hs       = r_bvalid & s_bready;
  assign w_aw_have    = r_aw_lat | w_aw_hs;
  assign w_w_have     = r_w_lat | w_w_hs;
  assign w_awaddr_eff = r_aw_lat ? r_awaddr : s_awaddr;
  assign w_wdata_eff  = r_w_lat ? r_wdata : s_wdata;
  assign w_wstrb_eff  = r_w_lat ? r_wstrb : s_wstrb;
  assign w_commit     = w_aw_have & w_w_have & ~r_bvalid;

  // Latches hold until the B handshake so no second transaction is accepted early
  assign w_aw_lat_nxt = w_b_hs ? 1'b0 : w_aw_have;
  assign w_w_lat_nxt  = w_b_hs ? 1'b0 : w_w_have;
  assign w_bvalid_nxt = w_commit | (r_bvalid & ~s_bready);

  // Write decode; anything at or above 0x10 is out of range
  assign w_wr_oob     = |(w_awaddr_eff >> 4);
  assign w_wr_ok      = w_commit & ~w_wr_oob;
  assign w_wr_ctrl    = w_wr_ok & (w_awaddr_eff[3:2] == CTRL_OFFS[3:2]);
  assign w_wr_data_in = w_wr_ok & (w_awaddr_eff[3:2] == DATA_IN_OFFS[3:2]);
  assign w_wr_status  = w_wr_ok & (w_awaddr_eff[3:2] == STATUS_OFFS[3:2]);

  // Start request and sticky flag set/clear terms
  assign w_core_idle  = (core_status_i == ST_IDLE);
  assign w_start_req  = w_wr_ctrl & w_wdata_eff[CTRL_START_BIT] & w_wstrb_eff[0];
  assign w_w1c_en     = w_wr_status & w_wstrb_eff[0];
  assign w_done_set   = (r_prev_status == ST_DONE);
  assign w_err_set    = (core_status_i == ST_ERROR);

  // Write address/data acceptance and response generation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_lat  <= 1'b0;
      r_w_lat   <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_aw_lat  <= w_aw_lat_nxt;
      r_w_lat   <= w_w_lat_nxt;
      r_awready <= ~w_aw_lat_nxt & ~w_bvalid_nxt;
      r_wready  <= ~w_w_lat_nxt & ~w_bvalid_nxt;
      r_bvalid  <= w_bvalid_nxt;
      if (w_aw_hs) begin
        r_awaddr <= s_awaddr;
      end
      if (w_w_hs) begin
        r_wdata <= s_wdata;
        r_wstrb <= s_wstrb;
      end
      if (w_commit) begin
        r_bresp <= w_wr_oob ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Register file update, start pulse and sticky flags (set wins over W1C)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data_in     <= '0;
      r_enable      <= 1'b0;
      r_done_sticky <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_start_rej   <= 1'b0;
      r_prev_status <= ST_IDLE;
    end else begin
      for (int unsigned b = 0; b < SW; b++) begin
        if (w_wr_data_in && w_wstrb_eff[b]) begin
          r_data_in[b*8 +: 8] <= w_wdata_eff[b*8 +: 8];
        end
      end
      r_enable      <= w_start_req & w_core_idle;
      r_prev_status <= core_status_i;
      r_done_sticky <= w_done_set |
                       (r_done_sticky & ~(w_w1c_en & w_wdata_eff[STATUS_DONE_BIT]));
      r_err_sticky  <= w_err_set |
                       (r_err_sticky & ~(w_w1c_en & w_wdata_eff[STATUS_ERR_BIT]));
      r_start_rej   <= (w_start_req & ~w_core_idle) |
                       (r_start_rej & ~(w_w1c_en & w_wdata_eff[STATUS_REJ_BIT]));
    end
  end

`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  // IRQ enable bit and registered interrupt output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl && w_wstrb_eff[0]) begin
        r_irq_en <= w_wdata_eff[CTRL_IRQ_EN_BIT];
      end
      r_irq <= r_irq_en & (r_done_sticky | r_err_sticky);
    end
  end

  assign irq_o = r_irq;
`endif

  // Read handshake and address range check
  assign w_ar_hs      = s_arvalid & r_arready;
  assign w_rvalid_nxt = w_ar_hs | (r_rvalid & ~s_rready);
  assign w_rd_oob     = |(s_araddr >> 4);

  // Read data mux; samples pre-write register values
  always_comb begin
    w_rd_word = '0;
    if (!w_rd_oob) begin
      case (s_araddr[3:2])
        CTRL_OFFS[3:2]: begin
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
          w_rd_word[CTRL_IRQ_EN_BIT] = r_irq_en;
`endif
        end
        DATA_IN_OFFS[3:2]:  w_rd_word = r_data_in;
        DATA_OUT_OFFS[3:2]: w_rd_word = core_data_i;
        STATUS_OFFS[3:2]: begin
          w_rd_word[STATUS_STATE_MSB:STATUS_STATE_LSB] = core_status_i;
          w_rd_word[STATUS_DONE_BIT]                   = r_done_sticky;
          w_rd_word[STATUS_ERR_BIT]                    = r_err_sticky;
          w_rd_word[STATUS_REJ_BIT]                    = r_start_rej;
        end
        default: w_rd_word = '0;
      endcase
    end
  end

  // Read address acceptance and held read response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_arready <= ~w_rvalid_nxt;
      r_rvalid  <= w_rvalid_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rd_word;
        r_rresp <= w_rd_oob ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign s_awready    = r_awready;
  assign s_wready     = r_wready;
  assign s_bvalid     = r_bvalid;
  assign s_bresp      = r_bresp;
  assign s_arready    = r_arready;
  assign s_rvalid     = r_rvalid;
  assign s_rresp      = r_rresp;
  assign s_rdata      = r_rdata;
  assign ipreg_data_o = r_data_in;
  assign enable_o     = r_enable;

endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// Directed self-checking bench for custom_axi_ip_regs.
module tb_custom_axi_ip_regs;
  import custom_axi_ip_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic [3:0]  s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [3:0]  s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] ipreg_data_o;
  logic        enable_o;
  logic [31:0] core_data_i;
  status_e     core_status_i;
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  logic        irq_o;
`endif

  int checks = 0;
  int errors = 0;
  logic en_after_commit;
  logic en_after_b;

  custom_axi_ip_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ipreg_data_o(ipreg_data_o), .enable_o(enable_o),
    .core_data_i(core_data_i), .core_status_i(core_status_i)
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // AW and W in the same cycle, then B accepted one cycle after bvalid rises
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    chk({tag, "_awwrdy"}, {30'd0, s_awready, s_wready}, 32'h3);
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    en_after_commit = enable_o;
    chk({tag, "_bvalid"}, 32'(s_bvalid), 32'h1);
    chk({tag, "_bresp"}, 32'(s_bresp), 32'h0);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    en_after_b = enable_o;
    chk({tag, "_bdone"}, 32'(s_bvalid), 32'h0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    s_araddr = addr; s_arvalid = 1'b1;
    chk({tag, "_arrdy"}, 32'(s_arready), 32'h1);
    step();
    s_arvalid = 1'b0;
    chk({tag, "_rvalid"}, {29'd0, s_rvalid, s_rresp}, 32'h4);
    rd = s_rdata;
    s_rready = 1'b1;
    step();
    s_rready = 1'b0;
    chk(tag, rd, exp);
  endtask

  initial begin
    rst_ni = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    core_data_i = '0; core_status_i = ST_IDLE;
    en_after_commit = 1'b0; en_after_b = 1'b0;

    // Reset state
    step();
    chk("rst_readys", {29'd0, s_awready, s_wready, s_arready}, 32'h0);
    chk("rst_valids", {30'd0, s_bvalid, s_rvalid}, 32'h0);
    chk("rst_resps", {28'd0, s_bresp, s_rresp}, 32'h0);
    chk("rst_rdata", s_rdata, 32'h0);
    chk("rst_ipreg", ipreg_data_o, 32'h0);
    chk("rst_enable", 32'(enable_o), 32'h0);
    rst_ni = 1'b1;
    step();

    // 1: AW+W together
    axi_write(4'h4, 32'hDEADBEEF, 4'hF, "t1_wr");
    chk("t1_ipreg", ipreg_data_o, 32'hDEADBEEF);
    axi_read(4'h4, 32'hDEADBEEF, "t1_rd");

    // 2: W three cycles ahead of AW, byte-0 strobe only
    axi_write(4'h4, 32'h11223344, 4'hF, "t2_pre");
    s_wdata = 32'h000000AA; s_wstrb = 4'h1; s_wvalid = 1'b1;
    step();
    s_wvalid = 1'b0;
    chk("t2_wrdy_low", 32'(s_wready), 32'h0);
    step();
    step();
    chk("t2_no_b_yet", 32'(s_bvalid), 32'h0);
    chk("t2_ipreg_old", ipreg_data_o, 32'h11223344);
    s_awaddr = 4'h4; s_awvalid = 1'b1;
    step();
    s_awvalid = 1'b0;
    chk("t2_bvalid", 32'(s_bvalid), 32'h1);
    chk("t2_ipreg_new", ipreg_data_o, 32'h112233AA);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    chk("t2_bdone", 32'(s_bvalid), 32'h0);
    step();
    chk("t2_single_b", 32'(s_bvalid), 32'h0);
    axi_read(4'h4, 32'h112233AA, "t2_rd");

    // Byte-1 strobe through an unaligned alias of DATA_IN
    axi_write(4'h7, 32'h0000FF00, 4'h2, "alias_wr");
    axi_read(4'h6, 32'h1122FFAA, "alias_rd");

    // 3: start with core idle, core runs to DONE
    axi_write(4'h0, 32'h1, 4'hF, "t3_wr");
    chk("t3_en_pulse", 32'(en_after_commit), 32'h1);
    chk("t3_en_end", 32'(en_after_b), 32'h0);
    core_status_i = ST_BUSY; core_data_i = 32'hDEADBEF0;
    step();
    core_status_i = ST_DONE;
    step();
    core_status_i = ST_IDLE;
    step();
    step();
    axi_read(4'hC, 32'h00000004, "t3_done_sticky");
    axi_read(4'h8, 32'hDEADBEF0, "t3_data_out");
    axi_read(4'h0, 32'h0, "t3_ctrl_reads0");
    axi_write(4'hC, 32'h4, 4'h1, "t3_w1c");
    axi_read(4'hC, 32'h0, "t3_cleared");

    // Read-only DATA_OUT ignores writes
    axi_write(4'h8, 32'h12345678, 4'hF, "ro_wr");
    axi_read(4'h8, 32'hDEADBEF0, "ro_rd");

    // 4: start while busy is rejected
    core_status_i = ST_BUSY;
    axi_write(4'h0, 32'h1, 4'h1, "t4_wr");
    chk("t4_no_pulse", {30'd0, en_after_commit, en_after_b}, 32'h0);
    axi_read(4'hC, 32'h00000011, "t4_rejected");
    axi_write(4'hC, 32'h10, 4'h1, "t4_w1c");
    core_status_i = ST_IDLE;
    axi_read(4'hC, 32'h0, "t4_cleared");

    // Error sticky
    core_status_i = ST_ERROR;
    step();
    core_status_i = ST_IDLE;
    axi_read(4'hC, 32'h00000008, "err_sticky");

    // Same-cycle read and write of DATA_IN: read sees old value
    s_awaddr = 4'h4; s_awvalid = 1'b1; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_araddr = 4'h4; s_arvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    chk("rw_bvalid_rvalid", {30'd0, s_bvalid, s_rvalid}, 32'h3);
    chk("rw_old_value", s_rdata, 32'h1122FFAA);
    s_bready = 1'b1; s_rready = 1'b1;
    step();
    s_bready = 1'b0; s_rready = 1'b0;
    axi_read(4'h4, 32'hCAFEF00D, "rw_new_value");

    // 5: read backpressure, live status changes underneath
    s_araddr = 4'hC; s_arvalid = 1'b1;
    step();
    s_arvalid = 1'b0;
    core_status_i = ST_BUSY;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_rvalid_arrdy", {30'd0, s_rvalid, s_arready}, 32'h2);
      chk("t5_hold_rdata", s_rdata, 32'h00000008);
      step();
    end
    s_rready = 1'b1;
    step();
    s_rready = 1'b0;
    chk("t5_released", {30'd0, s_rvalid, s_arready}, 32'h1);

    // 6: reset with a B response pending
    s_awaddr = 4'h4; s_awvalid = 1'b1; s_wdata = 32'h55; s_wstrb = 4'hF; s_wvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("t6_bvalid_pending", 32'(s_bvalid), 32'h1);
    core_data_i = '0;
    rst_ni = 1'b0;
    #1;
    chk("t6_bvalid_dropped", 32'(s_bvalid), 32'h0);
    chk("t6_ipreg_rst", ipreg_data_o, 32'h0);
    step();
    rst_ni = 1'b1;
    step();
    axi_read(4'h0, 32'h0, "t6_ctrl");
    axi_read(4'h4, 32'h0, "t6_data_in");
    axi_read(4'h8, 32'h0, "t6_data_out");
    axi_read(4'hC, 32'h1, "t6_status");
    chk("t6_enable", 32'(enable_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/custom_axi_ip_regs.md
Name: custom_axi_ip_regs

Overview:
AXI4-Lite slave register file that sits directly upstream of the custom AXI IP core and is its only host-facing interface. It holds the input operand, issues a one-cycle start pulse to the core, and exposes the core's result and state to software. It also tracks sticky done and error flags by watching the core's state over time.

Parameters:
DATA_WIDTH, 32, AXI data width; only 32 is supported.
ADDR_WIDTH, 4, AXI address width in bits. Decode uses addr[3:2]; addr[1:0] are ignored.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  AXI-Lite write address channel
s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  AXI-Lite write data channel
s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  AXI-Lite write response channel
s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  AXI-Lite read address channel
s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  AXI-Lite read data channel
ipreg_data_o  output  32  operand to the core; equals the DATA_IN register
enable_o  output  1  one-cycle start pulse to the core
core_data_i  input  32  result from the core
core_status_i  input  status_e  core state (IDLE/BUSY/DONE/ERROR)

Behaviour:
- Reset values: all ready/valid outputs 0, bresp/rresp 0, rdata 0, ipreg_data_o 0, enable_o 0, sticky flags 0. A reset mid-transaction drops any pending transaction.
- Register map:
  - 0x0 CTRL: bit0 START, write-1 self-clearing, reads 0.
  - 0x4 DATA_IN: read/write, honours wstrb per byte.
  - 0x8 DATA_OUT: read-only, returns live core_data_i.
  - 0xC STATUS: read-only except W1C bits. [1:0] live core_status_i; [2] DONE_STICKY (W1C); [3] ERR_STICKY (W1C); [4] START_REJECTED (W1C).
- Addresses with addr >= 0x10 (only possible when ADDR_WIDTH > 4) return SLVERR on read and write; writes there have no effect. Writes to read-only fields are ignored with OKAY.
- Write path:
  - AW and W are accepted independently and each is latched. awready=1 while no address is latched and bvalid=0; wready behaves the same way for data.
  - Once both are latched, the register update happens on the next edge and bvalid rises on that same edge.
  - bvalid is held until bready; the latches clear on the B handshake. Minimum latency: AW+W accepted in cycle N, bvalid in N+1.
- Read path:
  - arready=1 while rvalid=0. After an AR handshake in cycle N, rvalid and rdata are registered in N+1.
  - rvalid and rdata are held stable until rready. No outstanding-transaction depth beyond 1 per direction.
- Start:
  - A CTRL write with wdata[0]=1 and wstrb[0]=1 while core_status_i==IDLE drives enable_o=1 for exactly the cycle after the write commits.
  - If the core is not IDLE, there is no pulse and START_REJECTED is set.
- Sticky flags:
  - DONE_STICKY sets on the cycle following observation of core_status_i==DONE (uses a registered copy of the previous status).
  - ERR_STICKY sets whenever core_status_i==ERROR.
  - If a set and a W1C clear occur in the same cycle, set wins.
- Simultaneous read and write to the same register: the read returns the pre-write value.

Optional Feature:
CUSTOM_AXI_IP_REGS_IRQ_EN:
- Defined:
  - Adds an output port irq_o (1 bit, reset 0), registered: irq_o = CTRL[1] IRQ_ENABLE & (DONE_STICKY | ERR_STICKY).
  - CTRL[1] becomes a read/write bit with reset value 0.
- Undefined: no irq_o port; CTRL[1] reads 0 and writes to it are ignored.

Decomposition:
- custom_axi_ip_pkg (existing) holds status_e.
- Add to the package: register offset localparams CTRL_OFFS/DATA_IN_OFFS/DATA_OUT_OFFS/STATUS_OFFS, STATUS bit indices, and RESP_OKAY=2'b00 / RESP_SLVERR=2'b10.
- No sub-module; the write and read paths are two small always_ff blocks within this one module.

Test Plan:
1. AW and W presented in the same cycle to 0x4 with data 0xDEADBEEF and wstrb 0xF: bresp OKAY next cycle, ipreg_data_o=0xDEADBEEF, read of 0x4 returns 0xDEADBEEF.
2. W presented 3 cycles before AW to 0x4 with data 0x000000AA and wstrb 0x1, prior value 0x11223344: result 0x112233AA, single B response.
3. Write 0x1 to 0x0 with core IDLE: enable_o high exactly 1 cycle. Model core goes BUSY then DONE; DONE_STICKY reads 1, DATA_OUT=0xDEADBEF0. W1C 0x4 to 0xC clears the flag.
4. Start written while core BUSY: no enable_o pulse, STATUS[4]=1.
5. Backpressure: hold rready=0 for 5 cycles after a read of 0xC: rvalid and rdata stable, arready=0 throughout.
6. rst_ni asserted with bvalid pending: bvalid=0 immediately. After reset, all registers read 0 except STATUS[1:0], which reflects core_status_i.
